// File: rtl/idct_pkg.sv
// Shared constants and state encoding for the IDCT block scheduler and its
// 8x8 core handshake.
package idct_pkg;

  localparam int BLK_SIZE    = 64;
  localparam int ADDR_W      = 6;
  localparam int CORE_COEF_W = 16;
  localparam int CORE_PIX_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// searching with wrap-around.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    req2 = {req, req};
    rot  = N'(req2 >> rr_ptr);
    off  = '0;
    any  = 1'b0;
    // Rotated vector puts rr_ptr at bit 0; the lowest set bit is the winner.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = (IDX_W + 1)'(j);
        any = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    idx = sum[IDX_W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/idct_block_sched.sv
// Round-robin scheduler sharing one 8x8 IDCT core between N_REQ block
// requesters: load 64 coefficients, start, wait for done, drain 64 pixels.
module idct_block_sched
  import idct_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int COEF_W  = 16,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        grant,
  input  logic [N_REQ-1:0]        coef_valid,
  input  logic [N_REQ*COEF_W-1:0] coef_data,
  output logic [N_REQ-1:0]        coef_ready,
  output logic                    core_we,
  output logic [ADDR_W-1:0]       core_addr,
  output logic [COEF_W-1:0]       core_data,
  output logic                    core_start,
  input  logic                    core_done,
  output logic [ADDR_W-1:0]       core_raddr,
  input  logic [CORE_PIX_W-1:0]   core_rdata,
  output logic                    pix_valid,
  output logic [CORE_PIX_W-1:0]   pix_data,
  output logic [TAG_W-1:0]        pix_tag,
  output logic                    pix_last,
  input  logic                    pix_ready,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_SIZE - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

  if (N_REQ < 1 || N_REQ > 8) begin : g_bad_nreq
    $error("idct_block_sched: N_REQ must be in 1..8");
  end
  if (COEF_W != CORE_COEF_W) begin : g_bad_coef_w
    $error("idct_block_sched: COEF_W must match the core input width");
  end
  if ((1 << TAG_W) < N_REQ) begin : g_bad_tag_w
    $error("idct_block_sched: TAG_W too narrow for N_REQ");
  end

  state_e              state_q;
  logic [N_REQ-1:0]    grant_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    rr_ptr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic                err_q;
  logic                start_q;

  logic [N_REQ-1:0]    arb_gnt;
  logic [TAG_W-1:0]    arb_idx;
  logic                arb_any;
  logic                lane_valid;
  logic [COEF_W-1:0]   lane_data;
  logic                in_load;
  logic                in_drain;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    lane_valid = 1'b0;
    lane_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_q == TAG_W'(i)) begin
        lane_valid = coef_valid[i];
        lane_data  = coef_data[i*COEF_W +: COEF_W];
      end
    end
  end

  assign in_load  = (state_q == S_LOAD);
  assign in_drain = (state_q == S_DRAIN);

  // Outputs decode registered state only, so reset clears them asynchronously.
  assign grant       = grant_q;
  assign coef_ready  = in_load ? grant_q : '0;
  assign core_we     = in_load && lane_valid;
  assign core_addr   = cnt_q;
  assign core_data   = in_load ? lane_data : '0;
  assign core_start  = start_q;
  assign core_raddr  = cnt_q;
  assign pix_valid   = in_drain;
  assign pix_data    = in_drain ? core_rdata : '0;
  assign pix_tag     = tag_q;
  assign pix_last    = in_drain && (cnt_q == LAST_IDX);
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_gnt;
            tag_q    <= arb_idx;
            rr_ptr_q <= (arb_idx == TAG_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            cnt_q    <= '0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (lane_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              start_q <= 1'b1;
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          if (core_done) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else if (wdog_q == WDOG_MAX) begin
            // Abandon the block; no pixels are emitted for it.
            err_q   <= 1'b1;
            grant_q <= '0;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (pix_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              grant_q <= '0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_block_sched.sv
// Randomised scoreboard bench for idct_block_sched with a stub IDCT core
// whose output pixel is clamp(coefficient + 128).
module tb_idct_block_sched;

  localparam int N = 3;
  localparam int CW = 16;
  localparam int TW = 2;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, grant, coef_valid, coef_ready;
  logic [N*CW-1:0] coef_data;
  logic            core_we, core_start, core_done;
  logic [5:0]      core_addr, core_raddr;
  logic [CW-1:0]   core_data;
  logic [7:0]      core_rdata, pix_data;
  logic            pix_valid, pix_last, pix_ready, busy, err_timeout;
  logic [TW-1:0]   pix_tag;

  idct_block_sched #(.N_REQ(N), .COEF_W(CW), .TAG_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .coef_valid(coef_valid),
    .coef_data(coef_data), .coef_ready(coef_ready), .core_we(core_we),
    .core_addr(core_addr), .core_data(core_data), .core_start(core_start),
    .core_done(core_done), .core_raddr(core_raddr), .core_rdata(core_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_tag(pix_tag),
    .pix_last(pix_last), .pix_ready(pix_ready), .busy(busy),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         tag;
    bit         last;
  } exp_t;

  int          tests = 0, fails = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] coefq[N][$];
  int          pend[N];
  int          bi[N];
  logic [7:0]  cur_pix[N][64];
  bit          drop_en[N];
  int          vprob = 100, rprob = 100;
  bit          hang = 1'b0;
  logic [15:0] in_ram[64];
  logic [7:0]  out_ram[64];
  int          done_cyc = 0, start_cyc = 0, grise_cyc = 0;
  int          grant_log[$];
  int          blk_pix = 0, blocks_done = 0;

  assign core_rdata = out_ram[core_raddr];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix_of(logic [15:0] c);
    int v;
    v = int'($signed(c)) + 128;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic check(string name, int act, int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_block(int lane, bit zeros);
    for (int k = 0; k < 64; k++)
      coefq[lane].push_back(zeros ? 16'h0 : 16'($urandom_range(400) - 200));
    pend[lane]++;
  endtask

  task automatic check_all_zero(string p);
    check({p, "_grant"}, int'(grant), 0);
    check({p, "_coef_ready"}, int'(coef_ready), 0);
    check({p, "_core_we"}, int'(core_we), 0);
    check({p, "_core_start"}, int'(core_start), 0);
    check({p, "_pix_valid"}, int'(pix_valid), 0);
    check({p, "_pix_last"}, int'(pix_last), 0);
    check({p, "_busy"}, int'(busy), 0);
    check({p, "_err_timeout"}, int'(err_timeout), 0);
    check({p, "_core_addr"}, int'(core_addr), 0);
    check({p, "_core_data"}, int'(core_data), 0);
    check({p, "_core_raddr"}, int'(core_raddr), 0);
    check({p, "_pix_data"}, int'(pix_data), 0);
    check({p, "_pix_tag"}, int'(pix_tag), 0);
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    int outstanding;
    n = 0;
    forever begin
      outstanding = exp_q.size() + int'(busy);
      for (int i = 0; i < N; i++) outstanding += pend[i] + bi[i];
      if (outstanding == 0 || n >= budget) break;
      @(negedge clk);
      #2;
      n++;
    end
    check({name, "_drained"}, outstanding, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    blocks_done = 0;
    #2 rst = 1'b0;
  endtask

  // Requester lanes and downstream ready: sample handshakes mid-cycle, drive after the edge.
  initial begin
    bit [N-1:0] acc;
    req = '0; coef_valid = '0; coef_data = '0; pix_ready = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; bi[i] = 0; drop_en[i] = 1'b0; end
    forever begin
      @(negedge clk);
      acc = coef_valid & coef_ready;
      @(posedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < N; i++) begin coefq[i].delete(); pend[i] = 0; bi[i] = 0; end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (acc[i] && coefq[i].size() > 0) begin
            cur_pix[i][bi[i]] = pix_of(coefq[i].pop_front());
            bi[i]++;
            if (bi[i] == 64) begin
              if (!hang)
                for (int k = 0; k < 64; k++)
                  exp_q.push_back('{d: cur_pix[i][k], tag: i, last: (k == 63)});
              bi[i] = 0;
              pend[i]--;
            end
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        req[i]        = (pend[i] > 0) && !(drop_en[i] && bi[i] > 0);
        coef_valid[i] = (pend[i] > 0) && ($urandom_range(99) < 32'(vprob));
        coef_data[i*CW +: CW] = (pend[i] > 0) ? coefq[i][0] : 16'h0;
      end
      pix_ready = ($urandom_range(99) < 32'(rprob));
    end
  end

  // Stub IDCT core.
  initial begin
    bit act;
    int lat;
    act = 1'b0; lat = 0; core_done = 1'b0;
    for (int k = 0; k < 64; k++) begin in_ram[k] = '0; out_ram[k] = '0; end
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) act = 1'b0;
      else begin
        if (core_we) in_ram[core_addr] = core_data;
        if (act) begin
          if (lat == 0) begin core_done = 1'b1; act = 1'b0; done_cyc = cyc; end
          else lat--;
        end
        if (core_start && !hang) begin
          for (int k = 0; k < 64; k++) out_ram[k] = pix_of(in_ram[k]);
          act = 1'b1;
          lat = int'($urandom_range(6));
        end
      end
    end
  end

  // Grant / load-side monitor with a round-robin reference model.
  initial begin
    int ptr_m, g_lane, addr_m, exp_lane, act_lane;
    logic [N-1:0] prev_grant, prev_req;
    logic prev_start;
    ptr_m = 0; g_lane = 0; addr_m = 0;
    prev_grant = '0; prev_req = '0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ptr_m = 0; prev_grant = '0; prev_req = '0; prev_start = 1'b0;
      end else begin
        if (grant != '0 && prev_grant == '0) begin
          exp_lane = -1;
          for (int k = 0; k < N; k++)
            if (exp_lane < 0 && prev_req[(ptr_m + k) % N]) exp_lane = (ptr_m + k) % N;
          act_lane = -1;
          for (int k = 0; k < N; k++) if (grant[k]) act_lane = k;
          grant_log.push_back(act_lane);
          check("grant_choice", int'(grant), (exp_lane < 0) ? 0 : (1 << exp_lane));
          if (exp_lane >= 0) ptr_m = (exp_lane + 1) % N;
          g_lane = (exp_lane < 0) ? 0 : exp_lane;
          addr_m = 0;
          grise_cyc = cyc;
        end
        check("coef_ready_outside_grant", int'(coef_ready & ~grant), 0);
        if (core_we) begin
          check("core_addr", int'(core_addr), addr_m);
          if (coefq[g_lane].size() > 0)
            check("core_data", int'(core_data), int'(coefq[g_lane][0]));
          addr_m++;
        end
        if (core_start) begin
          check("start_pulse_width", int'(prev_start), 0);
          check("beats_before_start", addr_m, 64);
          start_cyc = cyc;
          if (vprob == 100) check("start_latency", cyc - grise_cyc, 64);
        end
        prev_grant = grant; prev_req = req; prev_start = core_start;
      end
    end
  end

  // Pixel monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    bit stalled;
    logic [7:0] sd;
    logic [TW-1:0] st;
    logic sl;
    exp_t e;
    stalled = 1'b0; sd = '0; st = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0; blk_pix = 0;
      end else if (pix_valid) begin
        if (stalled) begin
          check("stall_data", int'(pix_data), int'(sd));
          check("stall_tag", int'(pix_tag), int'(st));
          check("stall_last", int'(pix_last), int'(sl));
        end
        if (pix_ready) begin
          if (exp_q.size() == 0) check("pix_unexpected_valid", int'(pix_valid), 0);
          else begin
            e = exp_q.pop_front();
            check("pix_data", int'(pix_data), int'(e.d));
            check("pix_tag", int'(pix_tag), e.tag);
            check("pix_last", int'(pix_last), int'(e.last));
            blk_pix++;
            if (e.last) begin
              if (rprob == 100) check("last_latency", cyc - done_cyc, 64);
              blk_pix = 0;
              blocks_done++;
            end
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; sd = pix_data; st = pix_tag; sl = pix_last;
        end
      end else begin
        if (stalled) check("valid_dropped_while_stalled", int'(pix_valid), 1);
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    // 1: single requester, all-zero block, full rate.
    vprob = 100; rprob = 100;
    push_block(0, 1'b1);
    wait_idle("t1", 2000);
    check("t1_blocks", blocks_done, 1);
    check("t1_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // 2: round-robin from reset with all requesters active.
    pulse_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_block(i, 1'b0);
    wait_idle("t2", 5000);
    check("t2_blocks", blocks_done, 6);
    check("t2_order_count", grant_log.size(), 6);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("t2_order", grant_log[k], k % N);

    // 3: random back-pressure on both sides.
    vprob = 50; rprob = 50;
    base = blocks_done;
    for (int b = 0; b < 4; b++) push_block(int'($urandom_range(N - 1)), 1'b0);
    wait_idle("t3", 20000);
    check("t3_blocks", blocks_done - base, 4);

    // 4: core never finishes; watchdog abandons the block.
    vprob = 100; rprob = 100;
    hang = 1'b1;
    base = blocks_done;
    push_block(2, 1'b0);
    n = 0;
    while (!err_timeout && n < 300) begin @(negedge clk); #2; n++; end
    check("t4_err_set", int'(err_timeout), 1);
    check("t4_err_latency", cyc - start_cyc, 17);
    check("t4_busy_cleared", int'(busy), 0);
    wait_idle("t4a", 100);
    hang = 1'b0;
    push_block(0, 1'b1);
    wait_idle("t4b", 2000);
    check("t4_next_block", blocks_done - base, 1);
    check("t4_err_sticky", int'(err_timeout), 1);

    // 5: reset in the middle of a drain.
    push_block(1, 1'b0);
    n = 0;
    while (blk_pix < 20 && n < 2000) begin @(negedge clk); #2; n++; end
    check("t5_reached_pixel20", blk_pix, 20);
    rst = 1'b1;
    #1;
    check_all_zero("t5_midreset");
    repeat (2) @(negedge clk);
    exp_q.delete();
    blocks_done = 0;
    #2 rst = 1'b0;
    push_block(0, 1'b1);
    wait_idle("t5", 2000);
    check("t5_blocks_after_reset", blocks_done, 1);

    // 6: requester 1 drops req during LOAD.
    drop_en[1] = 1'b1;
    vprob = 70;
    base = blocks_done;
    push_block(1, 1'b0);
    wait_idle("t6", 3000);
    check("t6_blocks", blocks_done - base, 1);
    check("t6_grant", grant_log[grant_log.size() - 1], 1);
    drop_en[1] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
